register_rename_map: RTL and testbench

Register-rename map table for the out-of-order MIPS core, placed between the decoder and the active list. It translates the 32 logical source and destination register numbers of each decoded instruction into 64 physical register numbers, using a free list and a lowest-index priority pick. It also reports the destination's previous mapping to the active list, and accepts freed physical registers back from commit.

---
 rtl/register_rename_map.sv | 117 +++++++++++
 tb/tb_register_rename_map.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/register_rename_map.sv
// Purpose : map table translating logical registers to physical ones, with a free list and lowest-index allocation.
// Latency : lookups, allocation and ready are combinational; map and free list update at the next rising edge.
// Backpr. : rename_ready drops when a destination needs a register and none is free; nothing changes while stalled.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rename_valid, uses_*, *_addr  decoded instruction (rs/rt sources, rw destination)
//   out_uses_*                    pass-through of the operand-use flags
//   rs_phys, rt_phys              physical sources (0 when unused)
//   rw_phys                       newly allocated destination (0 when no allocation)
//   prev_phys_reg/_logical_reg    destination's mapping before this rename, for the active list
//   free_valid, free_phys         register released by commit
//   free_list_out, free_count     free bitmap and its population count
module register_rename_map #(
    parameter int NUM_LOGICAL = 32,
    parameter int NUM_PHYS    = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rename_valid,
    input  logic                            uses_rs,
    input  logic                            uses_rt,
    input  logic                            uses_rw,
    input  logic [$clog2(NUM_LOGICAL)-1:0]  rs_addr,
    input  logic [$clog2(NUM_LOGICAL)-1:0]  rt_addr,
    input  logic [$clog2(NUM_LOGICAL)-1:0]  rw_addr,
    output logic                            out_uses_rs,
    output logic                            out_uses_rt,
    output logic                            out_uses_rw,
    output logic [$clog2(NUM_PHYS)-1:0]     rs_phys,
    output logic [$clog2(NUM_PHYS)-1:0]     rt_phys,
    output logic [$clog2(NUM_PHYS)-1:0]     rw_phys,
    output logic [$clog2(NUM_PHYS)-1:0]     prev_phys_reg,
    output logic [$clog2(NUM_LOGICAL)-1:0]  prev_logical_reg,
    output logic                            rename_ready,
    input  logic                            free_valid,
    input  logic [$clog2(NUM_PHYS)-1:0]     free_phys,
    output logic [NUM_PHYS-1:0]             free_list_out,
    output logic [$clog2(NUM_PHYS):0]       free_count
);

    localparam int LW = $clog2(NUM_LOGICAL);
    localparam int PW = $clog2(NUM_PHYS);

    logic [PW-1:0]     map_q [NUM_LOGICAL];
    logic [PW-1:0]     map_d [NUM_LOGICAL];
    logic [NUM_PHYS-1:0] free_q;
    logic [NUM_PHYS-1:0] free_d;

    logic          need_alloc;
    logic          any_free;
    logic          do_alloc;
    logic [PW-1:0] alloc_idx;
    logic [PW:0]   count;

    assign out_uses_rs = uses_rs;
    assign out_uses_rt = uses_rt;
    assign out_uses_rw = uses_rw;

    // Sources read the pre-update map, so rs == rw sees the old mapping.
    assign rs_phys = uses_rs ? map_q[rs_addr] : '0;
    assign rt_phys = uses_rt ? map_q[rt_addr] : '0;

    // r0 is hardwired to physical 0 and never consumes a register.
    assign need_alloc = rename_valid & uses_rw & (rw_addr != '0);
    assign any_free   = |free_q;
    assign do_alloc   = need_alloc & any_free;

    assign rw_phys          = do_alloc ? alloc_idx : '0;
    assign rename_ready     = ~need_alloc | any_free;
    assign prev_phys_reg    = map_q[rw_addr];
    assign prev_logical_reg = rw_addr;

    assign free_list_out = free_q;
    assign free_count    = count;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_PHYS - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_idx = PW'(i);
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_PHYS; i++) begin
            count = count + {{PW{1'b0}}, free_q[i]};
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LOGICAL; i++) map_d[i] = map_q[i];
        free_d = free_q;
        if (do_alloc) begin
            map_d[rw_addr]    = alloc_idx;
            free_d[alloc_idx] = 1'b0;
        end
        // Release is applied after allocation so it wins on a collision.
        if (free_valid && (free_phys != '0)) free_d[free_phys] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOGICAL; i++) map_q[i] <= PW'(i);
            free_q <= {{(NUM_PHYS - NUM_LOGICAL){1'b1}}, {NUM_LOGICAL{1'b0}}};
        end else begin
            for (int i = 0; i < NUM_LOGICAL; i++) map_q[i] <= map_d[i];
            free_q <= free_d;
        end
    end

    // LW kept for readers matching widths against the port list.
    logic unused_lw;
    assign unused_lw = (LW > 0);

endmodule

// File: tb/tb_register_rename_map.sv
module tb_register_rename_map;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rename_valid = 1'b0;
    logic        uses_rs = 1'b0, uses_rt = 1'b0, uses_rw = 1'b0;
    logic [4:0]  rs_addr = '0, rt_addr = '0, rw_addr = '0;
    logic        out_uses_rs, out_uses_rt, out_uses_rw;
    logic [5:0]  rs_phys, rt_phys, rw_phys, prev_phys_reg;
    logic [4:0]  prev_logical_reg;
    logic        rename_ready;
    logic        free_valid = 1'b0;
    logic [5:0]  free_phys = '0;
    logic [63:0] free_list_out;
    logic [6:0]  free_count;

    register_rename_map dut (
        .clk(clk), .rst(rst), .rename_valid(rename_valid),
        .uses_rs(uses_rs), .uses_rt(uses_rt), .uses_rw(uses_rw),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rw_addr(rw_addr),
        .out_uses_rs(out_uses_rs), .out_uses_rt(out_uses_rt), .out_uses_rw(out_uses_rw),
        .rs_phys(rs_phys), .rt_phys(rt_phys), .rw_phys(rw_phys),
        .prev_phys_reg(prev_phys_reg), .prev_logical_reg(prev_logical_reg),
        .rename_ready(rename_ready), .free_valid(free_valid), .free_phys(free_phys),
        .free_list_out(free_list_out), .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  rs, rt, rw, prev;
        logic [4:0]  prevl;
        logic        ready, urs, urt, urw;
        logic [63:0] flist;
        logic [6:0]  fcount;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: logical->physical table and a set of free registers.
    int   ref_map [32];
    bit   ref_free[64];
    int   retired[$];     // previous mappings awaiting release by commit

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_map[i] = i;
        for (int i = 0; i < 64; i++) ref_free[i] = (i >= 32);
        retired.delete();
    endtask

    // Drive one cycle of stimulus, record the expected response, advance the model.
    task automatic issue(input bit v, input bit urs, input bit urt, input bit urw,
                         input int rs, input int rt, input int rw,
                         input bit fv, input int fp);
        exp_t e;
        bit   need, any;
        int   low, cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        rename_valid = v; uses_rs = urs; uses_rt = urt; uses_rw = urw;
        rs_addr = 5'(rs); rt_addr = 5'(rt); rw_addr = 5'(rw);
        free_valid = fv; free_phys = 6'(fp);

        need = v && urw && (rw != 0);
        low = -1; cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (ref_free[i]) begin
                cnt++;
                if (low < 0) low = i;
            end
            e.flist[i] = ref_free[i];
        end
        any = (cnt > 0);
        e.rs     = urs ? 6'(ref_map[rs]) : 6'd0;
        e.rt     = urt ? 6'(ref_map[rt]) : 6'd0;
        e.rw     = (need && any) ? 6'(low) : 6'd0;
        e.prev   = 6'(ref_map[rw]);
        e.prevl  = 5'(rw);
        e.ready  = !need || any;
        e.urs = urs; e.urt = urt; e.urw = urw;
        e.fcount = 7'(cnt);
        exp_q.push_back(e);

        if (need && any) begin
            if (ref_map[rw] != 0) retired.push_back(ref_map[rw]);
            ref_map[rw] = low;
            ref_free[low] = 1'b0;
        end
        if (fv && fp != 0) ref_free[fp] = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        rename_valid = 1'b0; free_valid = 1'b0;
        model_reset();
    endtask

    // Monitor: the DUT is combinational, so every issued cycle yields a response mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rs_phys",          64'(rs_phys),          64'(e.rs));
            chk("rt_phys",          64'(rt_phys),          64'(e.rt));
            chk("rw_phys",          64'(rw_phys),          64'(e.rw));
            chk("prev_phys_reg",    64'(prev_phys_reg),    64'(e.prev));
            chk("prev_logical_reg", 64'(prev_logical_reg), 64'(e.prevl));
            chk("rename_ready",     64'(rename_ready),     64'(e.ready));
            chk("out_uses",  64'({out_uses_rs, out_uses_rt, out_uses_rw}), 64'({e.urs, e.urt, e.urw}));
            chk("free_list_out",    free_list_out,         e.flist);
            chk("free_count",       64'(free_count),       64'(e.fcount));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);

        // add r3, r1, r2 then two more renames of r3, then a read of r3
        issue(1, 1, 1, 1, 1, 2, 3, 0, 0);
        issue(1, 0, 0, 1, 0, 0, 3, 0, 0);
        issue(1, 1, 0, 0, 3, 0, 0, 0, 0);

        // Exhaust the free list, then one stalled rename with a release of 40
        while (ref_free.sum() with (int'(item)) > 0)
            issue(1, 1, 1, 1, $urandom_range(31), $urandom_range(31), $urandom_range(1, 31), 0, 0);
        issue(1, 0, 0, 1, 0, 0, 7, 0, 0);
        issue(1, 0, 0, 1, 0, 0, 7, 1, 40);
        issue(1, 0, 0, 1, 0, 0, 7, 0, 0);

        // Write to r0: no allocation, always ready
        issue(1, 1, 0, 1, 0, 0, 0, 0, 0);
        issue(1, 1, 1, 0, 0, 5, 0, 0, 0);

        // Simultaneous allocate (gets 34) and release of 33
        do_reset();
        issue(1, 0, 0, 1, 0, 0, 3, 0, 0);
        issue(1, 0, 0, 1, 0, 0, 3, 0, 0);
        issue(1, 0, 0, 1, 0, 0, 4, 1, 33);
        issue(1, 1, 0, 0, 4, 0, 0, 0, 0);
        issue(1, 0, 0, 1, 0, 0, 9, 0, 0);

        // Reset after several renames: identity map, r5 -> 5
        do_reset();
        issue(1, 1, 1, 0, 5, 3, 0, 0, 0);

        // Randomised traffic with commit-driven releases and occasional resets
        for (int c = 0; c < 600; c++) begin
            bit fv; int fp;
            if ($urandom_range(99) == 0) begin
                do_reset();
                continue;
            end
            fv = 0; fp = 0;
            if (retired.size() > 0 && $urandom_range(99) < 35) begin
                fv = 1; fp = retired.pop_front();
            end else if ($urandom_range(99) < 3) begin
                fv = 1; fp = $urandom_range(63);   // stray releases, incl. 0 and already-free
            end
            issue($urandom_range(99) < 75, $urandom_range(1), $urandom_range(1), $urandom_range(99) < 80,
                  $urandom_range(31), $urandom_range(31), $urandom_range(31), fv, fp);
        end

        @(posedge clk); @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
